node_bank_sched: RTL and testbench
==================================

# node_bank_sched

Per-bank packet scheduler between one mesh router port and the `NODES_PER_BANK` node instances of a bank. Ingress packets are demultiplexed to the node selected by `addr.z`. Egress packets from all nodes share the single router output through a round-robin arbiter and a one-entry registered output stage. The block also latches the `CTRL_DONE` answer and counts misaddressed packets.

## Interface
Parameters:
- `NODES_PER_BANK`, default 4: node slots in the bank; must be ≥2.
- `ZW`, default `$clog2(NODES_PER_BANK)`: width of the slot index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid_in`  in  1  router→bank packet valid.
- `ready_in`  out  1  bank accepts the router packet.
- `in_pkt`  in  pkt_t  router→bank packet.
- `valid_out`  out  1  bank→router packet valid (registered).
- `ready_out`  in  1  router accepts the packet.
- `out_pkt`  out  pkt_t  bank→router packet (registered).
- `node_valid_in`  out  [NODES_PER_BANK]  per-node ingress valid.
- `node_ready_in`  in  [NODES_PER_BANK]  per-node ingress ready.
- `node_pkt_in`  out  pkt_t [NODES_PER_BANK]  per-node ingress packet (broadcast copy of `in_pkt`).
- `node_valid_out`  in  [NODES_PER_BANK]  per-node egress request.
- `node_ready_out`  out  [NODES_PER_BANK]  per-node egress grant/accept.
- `node_pkt_out`  in  pkt_t [NODES_PER_BANK]  per-node egress packet.
- `done`  out  1  sticky: a `CTRL_DONE` packet has been forwarded.
- `result`  out  MAX_PATHS_BITS  `sum_t.value` of the first forwarded `CTRL_DONE`.
- `drop_count`  out  16  count of ingress packets with `addr.z ≥ NODES_PER_BANK`; saturates at 0xFFFF.

## Operation
Ingress (combinational, no storage):
- `node_pkt_in[i] = in_pkt` for all i.
- `node_valid_in[i] = valid_in && in_pkt.addr.z == i`.
- `ready_in = node_ready_in[in_pkt.addr.z]` when `addr.z < NODES_PER_BANK`.
- When `addr.z ≥ NODES_PER_BANK`: `ready_in = 1`, no node valid is asserted, the packet is consumed, and `drop_count` increments.

Egress: output register with states EMPTY and FULL.
- `can_load = (state == EMPTY) || (valid_out && ready_out)`.
- Grant search is combinational over `node_valid_out`, starting at `rr_ptr` and wrapping modulo `NODES_PER_BANK`. The first requester found is `g`.
- If `can_load` and any request exists: `node_ready_out[g] = 1` (one-hot, only g). `out_pkt <= node_pkt_out[g]`, state becomes FULL, and `rr_ptr <= (g+1) mod NODES_PER_BANK`.
- If `can_load` and there are no requests: state becomes EMPTY (if draining). `rr_ptr` is unchanged.
- If not `can_load`: all `node_ready_out = 0`, and `out_pkt`/`valid_out` hold stable.
- `valid_out = (state == FULL)`.

Done capture:
- On an output handshake with `out_pkt.ctrl == CTRL_DONE` and `done == 0`: `done <= 1` and `result <= out_pkt.data.sum_t.value`.
- Later `CTRL_DONE` packets are still forwarded but do not change `result`.

Widths:
- `rr_ptr` is ZW bits. Wrap is explicit compare-to-`NODES_PER_BANK-1`, not a power-of-two mask.
- `drop_count` increments only when `drop_count != 16'hFFFF`.

## Timing
- Reset (async assert, sync-safe release) puts registers at: state=EMPTY, `valid_out=0`, `out_pkt='0`, `rr_ptr=0`, `done=0`, `result=0`, `drop_count=0`.
- Reset mid-operation discards the held packet without a handshake.
- Ingress latency is 0 cycles; it is purely combinational from `valid_in`/`in_pkt` to the node.
- Egress latency: a node grant in cycle N gives `valid_out=1` in cycle N+1.
- Egress throughput is one packet per cycle while `ready_out` stays high (load-while-drain).
- Backpressure: while FULL and `ready_out=0`, no grant is issued and `out_pkt` is bit-stable.
- Fairness: a continuously requesting node waits at most `NODES_PER_BANK-1` grants.
- Handshakes follow AXI-style valid/ready. `valid_out` never drops without `ready_out`. Nodes must hold `node_pkt_out` stable until granted.
- Simultaneous ingress and egress for the same node are independent and both allowed in the same cycle.

## Test plan
- Reset, then node 2 requests with `CTRL_SUM` value 5 and `ready_out=1` → `node_ready_out=4'b0100` in cycle 0, `valid_out=1` with value 5 in cycle 1, and `rr_ptr=3`.
- All 4 nodes request continuously with `ready_out=1` → grant order 0,1,2,3,0,…, and one `valid_out` per cycle with no bubbles.
- Node 1 is granted, then `ready_out=0` for 3 cycles while nodes 0 and 3 request → `out_pkt` holds node 1's packet, all `node_ready_out=0`. After `ready_out` rises, node 3 is granted next, then node 0.
- Ingress packet with `addr.z=1` and `node_ready_in=4'b0000` → `node_valid_in=4'b0010` and `ready_in=0`. Setting `node_ready_in[1]=1` gives `ready_in=1`.
- Ingress `addr.z=5` with `NODES_PER_BANK=4` → `ready_in=1`, no `node_valid_in`, and `drop_count` goes 0→1.
- Node 0 sends `CTRL_DONE` value 42, then `CTRL_DONE` value 7 → both are forwarded, `done=1`, and `result` stays 42. Async `rst` pulse mid-stream → `valid_out=0`, `done=0`, `result=0` immediately.

Source files
------------

// File: rtl/node_bank_sched.sv
// Per-bank packet scheduler: demuxes router ingress to the addressed node,
// round-robin arbitrates node egress into a one-entry registered output
// stage, latches the first CTRL_DONE result and counts misaddressed packets.

package node_pkg;
  localparam int MAX_PATHS_BITS = 16;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    CTRL_SUM  = 2'd1,
    CTRL_DONE = 2'd2,
    CTRL_CFG  = 2'd3
  } ctrl_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } addr_t;

  typedef struct packed {
    logic [MAX_PATHS_BITS-1:0] value;
  } sum_s;

  typedef struct packed {
    sum_s sum_t;
  } data_t;

  typedef struct packed {
    addr_t addr;
    ctrl_t ctrl;
    data_t data;
  } pkt_t;
endpackage

module node_bank_sched
  import node_pkg::*;
#(
  parameter int NODES_PER_BANK = 4,
  parameter int ZW             = $clog2(NODES_PER_BANK)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  pkt_t                            in_pkt,
  output logic                            valid_out,
  input  logic                            ready_out,
  output pkt_t                            out_pkt,
  output logic [NODES_PER_BANK-1:0]       node_valid_in,
  input  logic [NODES_PER_BANK-1:0]       node_ready_in,
  output pkt_t [NODES_PER_BANK-1:0]       node_pkt_in,
  input  logic [NODES_PER_BANK-1:0]       node_valid_out,
  output logic [NODES_PER_BANK-1:0]       node_ready_out,
  input  pkt_t [NODES_PER_BANK-1:0]       node_pkt_out,
  output logic                            done,
  output logic [MAX_PATHS_BITS-1:0]       result,
  output logic [15:0]                     drop_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [ZW-1:0]   rr_ptr;
  logic [31:0]     z_ext;
  logic            in_range;
  logic            drop;
  logic            can_load;
  logic            found;
  int              g_int;
  int              idx;
  logic [ZW-1:0]   rr_next;

  assign z_ext     = 32'(in_pkt.addr.z);
  assign in_range  = (z_ext < NODES_PER_BANK);
  assign drop      = valid_in && !in_range;
  assign valid_out = (state == FULL);
  assign can_load  = (state == EMPTY) || (valid_out && ready_out);
  assign rr_next   = (g_int == NODES_PER_BANK - 1) ? '0 : ZW'(g_int + 1);

  // Ingress demux: broadcast the packet, steer valid/ready by addr.z; out-of-range is swallowed.
  always_comb begin
    ready_in = !in_range;
    for (int i = 0; i < NODES_PER_BANK; i++) begin
      node_pkt_in[i]   = in_pkt;
      node_valid_in[i] = valid_in && (z_ext == i);
      if (z_ext == i) ready_in = node_ready_in[i];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping by explicit compare.
  always_comb begin
    found = 1'b0;
    g_int = 0;
    idx   = 0;
    for (int k = 0; k < NODES_PER_BANK; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NODES_PER_BANK) idx = idx - NODES_PER_BANK;
      if (!found && node_valid_out[idx]) begin
        found = 1'b1;
        g_int = idx;
      end
    end
  end

  // One-hot grant, only when the output stage can take a packet.
  always_comb begin
    for (int i = 0; i < NODES_PER_BANK; i++)
      node_ready_out[i] = can_load && found && (g_int == i);
  end

  // Output stage FSM: load-while-drain, hold stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      out_pkt <= '0;
      rr_ptr  <= '0;
    end else if (can_load) begin
      if (found) begin
        state   <= FULL;
        out_pkt <= node_pkt_out[g_int];
        rr_ptr  <= rr_next;
      end else begin
        state   <= EMPTY;
      end
    end
  end

  // Latch the value of the first CTRL_DONE that leaves the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
    end else if (valid_out && ready_out && out_pkt.ctrl == CTRL_DONE && !done) begin
      done   <= 1'b1;
      result <= out_pkt.data.sum_t.value;
    end
  end

  // Saturating count of misaddressed ingress packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end

endmodule

// File: tb/tb_node_bank_sched.sv
// Directed testbench for node_bank_sched with NODES_PER_BANK = 4.
module tb_node_bank_sched;
  import node_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid_in = 1'b0;
  logic           ready_in;
  pkt_t           in_pkt = '0;
  logic           valid_out;
  logic           ready_out = 1'b0;
  pkt_t           out_pkt;
  logic [N-1:0]   node_valid_in;
  logic [N-1:0]   node_ready_in = '0;
  pkt_t [N-1:0]   node_pkt_in;
  logic [N-1:0]   node_valid_out = '0;
  logic [N-1:0]   node_ready_out;
  pkt_t [N-1:0]   node_pkt_out = '0;
  logic           done;
  logic [15:0]    result;
  logic [15:0]    drop_count;

  int tests_run = 0;
  int fails = 0;

  node_bank_sched #(.NODES_PER_BANK(N)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .in_pkt(in_pkt),
    .valid_out(valid_out), .ready_out(ready_out), .out_pkt(out_pkt),
    .node_valid_in(node_valid_in), .node_ready_in(node_ready_in), .node_pkt_in(node_pkt_in),
    .node_valid_out(node_valid_out), .node_ready_out(node_ready_out), .node_pkt_out(node_pkt_out),
    .done(done), .result(result), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic [3:0] z, input ctrl_t c, input logic [15:0] v);
    pkt_t p;
    p = '0;
    p.addr.z = z;
    p.ctrl = c;
    p.data.sum_t.value = v;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    node_valid_out = '0;
    ready_out = 1'b0;
    valid_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if (valid_out !== 1'b0 || out_pkt !== pkt_t'('0)) begin
      fails++; $display("FAIL reset_out valid_out=%b out_pkt=%h want 0/0", valid_out, out_pkt);
    end
    tests_run++;
    if (done !== 1'b0 || result !== 16'd0 || drop_count !== 16'd0) begin
      fails++; $display("FAIL reset_regs done=%b result=%0d drop=%0d want 0/0/0", done, result, drop_count);
    end
    tests_run++;
    if (node_ready_out !== 4'b0000) begin
      fails++; $display("FAIL reset_grant got %b want 0000", node_ready_out);
    end
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    node_pkt_out[2] = mk(4'd0, CTRL_SUM, 16'd5);
    node_valid_out = 4'b0100;
    ready_out = 1'b1;
    #1;
    tests_run++;
    if (node_ready_out !== 4'b0100) begin
      fails++; $display("FAIL single_grant got %b want 0100", node_ready_out);
    end
    tests_run++;
    if (valid_out !== 1'b0) begin
      fails++; $display("FAIL single_lat0 valid_out=%b want 0", valid_out);
    end
    step();
    node_valid_out = 4'b0000;
    #1;
    tests_run++;
    if (valid_out !== 1'b1 || out_pkt.data.sum_t.value !== 16'd5) begin
      fails++; $display("FAIL single_out valid=%b value=%0d want 1/5", valid_out, out_pkt.data.sum_t.value);
    end
    tests_run++;
    if (dut.rr_ptr !== 2'd3) begin
      fails++; $display("FAIL single_rrptr got %0d want 3", dut.rr_ptr);
    end
    step();
    tests_run++;
    if (valid_out !== 1'b0) begin
      fails++; $display("FAIL single_drain valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_rr_all();
    do_reset();
    for (int i = 0; i < N; i++) node_pkt_out[i] = mk(4'd0, CTRL_SUM, 16'(10 + i));
    node_valid_out = 4'b1111;
    ready_out = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      tests_run++;
      if (node_ready_out !== 4'(1 << (c % 4))) begin
        fails++; $display("FAIL rr_grant cycle %0d got %b want %b", c, node_ready_out, 4'(1 << (c % 4)));
      end
      step();
      tests_run++;
      if (valid_out !== 1'b1 || out_pkt.data.sum_t.value !== 16'(10 + c % 4)) begin
        fails++; $display("FAIL rr_out cycle %0d valid=%b value=%0d want 1/%0d", c, valid_out, out_pkt.data.sum_t.value, 10 + c % 4);
      end
    end
    node_valid_out = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) node_pkt_out[i] = mk(4'd0, CTRL_SUM, 16'(20 + i));
    node_valid_out = 4'b0010;
    ready_out = 1'b0;
    #1;
    tests_run++;
    if (node_ready_out !== 4'b0010) begin
      fails++; $display("FAIL bp_first_grant got %b want 0010", node_ready_out);
    end
    step();
    node_valid_out = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (node_ready_out !== 4'b0000 || valid_out !== 1'b1 || out_pkt !== mk(4'd0, CTRL_SUM, 16'd21)) begin
        fails++; $display("FAIL bp_hold cycle %0d grant=%b valid=%b value=%0d want 0000/1/21", c, node_ready_out, valid_out, out_pkt.data.sum_t.value);
      end
      step();
    end
    ready_out = 1'b1;
    #1;
    tests_run++;
    if (node_ready_out !== 4'b1000) begin
      fails++; $display("FAIL bp_next_grant got %b want 1000", node_ready_out);
    end
    step();
    node_valid_out = 4'b0001;
    #1;
    tests_run++;
    if (out_pkt.data.sum_t.value !== 16'd23 || node_ready_out !== 4'b0001) begin
      fails++; $display("FAIL bp_node3 value=%0d grant=%b want 23/0001", out_pkt.data.sum_t.value, node_ready_out);
    end
    step();
    node_valid_out = '0;
    #1;
    tests_run++;
    if (valid_out !== 1'b1 || out_pkt.data.sum_t.value !== 16'd20) begin
      fails++; $display("FAIL bp_node0 valid=%b value=%0d want 1/20", valid_out, out_pkt.data.sum_t.value);
    end
    step();
  endtask

  task automatic test_ingress();
    do_reset();
    in_pkt = mk(4'd1, CTRL_SUM, 16'd77);
    valid_in = 1'b1;
    node_ready_in = 4'b0000;
    #1;
    tests_run++;
    if (node_valid_in !== 4'b0010 || ready_in !== 1'b0) begin
      fails++; $display("FAIL ing_stall node_valid_in=%b ready_in=%b want 0010/0", node_valid_in, ready_in);
    end
    tests_run++;
    if (node_pkt_in[3] !== in_pkt || node_pkt_in[0] !== in_pkt) begin
      fails++; $display("FAIL ing_bcast got %h/%h want %h", node_pkt_in[3], node_pkt_in[0], in_pkt);
    end
    node_ready_in = 4'b0010;
    #1;
    tests_run++;
    if (ready_in !== 1'b1) begin
      fails++; $display("FAIL ing_ready got %b want 1", ready_in);
    end
    node_ready_in = 4'b1101;
    #1;
    tests_run++;
    if (ready_in !== 1'b0) begin
      fails++; $display("FAIL ing_ready_sel got %b want 0", ready_in);
    end
    step();
    tests_run++;
    if (drop_count !== 16'd0) begin
      fails++; $display("FAIL ing_nodrop got %0d want 0", drop_count);
    end
    in_pkt = mk(4'd5, CTRL_SUM, 16'd1);
    #1;
    tests_run++;
    if (ready_in !== 1'b1 || node_valid_in !== 4'b0000) begin
      fails++; $display("FAIL ing_bad_addr ready_in=%b node_valid_in=%b want 1/0000", ready_in, node_valid_in);
    end
    step();
    valid_in = 1'b0;
    tests_run++;
    if (drop_count !== 16'd1) begin
      fails++; $display("FAIL ing_drop got %0d want 1", drop_count);
    end
    step();
    tests_run++;
    if (drop_count !== 16'd1) begin
      fails++; $display("FAIL ing_drop_hold got %0d want 1", drop_count);
    end
  endtask

  task automatic test_done();
    do_reset();
    node_pkt_out[0] = mk(4'd0, CTRL_DONE, 16'd42);
    node_valid_out = 4'b0001;
    ready_out = 1'b1;
    step();
    node_pkt_out[0] = mk(4'd0, CTRL_DONE, 16'd7);
    #1;
    tests_run++;
    if (out_pkt.data.sum_t.value !== 16'd42 || done !== 1'b0 || node_ready_out !== 4'b0001) begin
      fails++; $display("FAIL done_first value=%0d done=%b grant=%b want 42/0/0001", out_pkt.data.sum_t.value, done, node_ready_out);
    end
    step();
    node_valid_out = '0;
    #1;
    tests_run++;
    if (done !== 1'b1 || result !== 16'd42 || valid_out !== 1'b1 || out_pkt.data.sum_t.value !== 16'd7) begin
      fails++; $display("FAIL done_second done=%b result=%0d valid=%b value=%0d want 1/42/1/7", done, result, valid_out, out_pkt.data.sum_t.value);
    end
    step();
    tests_run++;
    if (done !== 1'b1 || result !== 16'd42 || valid_out !== 1'b0) begin
      fails++; $display("FAIL done_sticky done=%b result=%0d valid=%b want 1/42/0", done, result, valid_out);
    end
    node_pkt_out[0] = mk(4'd0, CTRL_SUM, 16'd9);
    node_valid_out = 4'b0001;
    ready_out = 1'b0;
    step();
    node_valid_out = '0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || done !== 1'b0 || result !== 16'd0) begin
      fails++; $display("FAIL async_rst valid=%b done=%b result=%0d want 0/0/0", valid_out, done, result);
    end
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (valid_out !== 1'b0 || out_pkt !== pkt_t'('0)) begin
      fails++; $display("FAIL rst_discard valid=%b out_pkt=%h want 0/0", valid_out, out_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_backpressure();
    test_ingress();
    test_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
